// File: rtl/lm32_tlb_refill.sv
// Two-level page-table walker: turns a TLB miss into a TLB update or a refill fault.
// Latency: accept T, L1 bus T+1, L2 bus T+2, update T+3, idle T+4; +1 cycle per wait state.
// Backpressure: miss_req is acked only in IDLE; bus waits are unbounded, abort never drops a bus cycle.
module lm32_tlb_refill #(
    parameter int page_size = 4096
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] ptbr,
    input  logic        miss_req,
    input  logic [31:0] miss_vaddr,
    output logic        miss_ack,
    input  logic        abort,
    output logic        busy,
    output logic [31:0] wb_adr_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    output logic        tlb_update,
    output logic [31:0] tlb_update_vaddr,
    output logic [31:0] tlb_update_paddr,
    output logic        refill_fault,
    output logic [1:0]  fault_code,
    output logic [31:0] fault_vaddr
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_L1     = 3'd1,
        S_L2     = 3'd2,
        S_UPDATE = 3'd3,
        S_FAULT  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] vaddr_q, vaddr_d;
    logic [19:0] base_q, base_d;
    logic [19:0] pte1_q, pte1_d;
    logic        abort_q, abort_d;
    logic [1:0]  code_n;

    logic        busy_d, cyc_d, upd_d, flt_d;
    logic [31:0] adr_d, uv_d, up_d, fv_d;
    logic        accept, term, kill;
    logic        unused_bits;

    // Low PTE flag bits and the page offset of ptbr carry no meaning here.
    assign unused_bits = ^{ptbr[11:0], wb_dat_i[11:1], page_size == 4096};

    assign accept   = (state_q == S_IDLE) && miss_req;
    assign term     = wb_ack_i | wb_err_i;
    assign kill     = abort | abort_q;
    assign miss_ack = accept;
    assign wb_stb_o = wb_cyc_o;
    assign wb_we_o  = 1'b0;
    assign wb_sel_o = 4'hF;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q          <= S_IDLE;
            vaddr_q          <= '0;
            base_q           <= '0;
            pte1_q           <= '0;
            abort_q          <= 1'b0;
            busy             <= 1'b0;
            wb_cyc_o         <= 1'b0;
            wb_adr_o         <= '0;
            tlb_update       <= 1'b0;
            tlb_update_vaddr <= '0;
            tlb_update_paddr <= '0;
            refill_fault     <= 1'b0;
            fault_code       <= 2'd0;
            fault_vaddr      <= '0;
        end else begin
            state_q          <= state_d;
            vaddr_q          <= vaddr_d;
            base_q           <= base_d;
            pte1_q           <= pte1_d;
            abort_q          <= abort_d;
            busy             <= busy_d;
            wb_cyc_o         <= cyc_d;
            wb_adr_o         <= adr_d;
            tlb_update       <= upd_d;
            tlb_update_vaddr <= uv_d;
            tlb_update_paddr <= up_d;
            refill_fault     <= flt_d;
            fault_code       <= code_n;
            fault_vaddr      <= fv_d;
        end
    end

    // Error beats ack; a pending abort turns any termination into a silent return to IDLE.
    always_comb begin
        state_d = state_q;
        code_n  = 2'd0;
        case (state_q)
            S_IDLE: begin
                if (miss_req) state_d = S_L1;
            end
            S_L1: begin
                if (term) begin
                    if (kill) begin
                        state_d = S_IDLE;
                    end else if (wb_err_i) begin
                        state_d = S_FAULT;
                        code_n  = 2'd3;
                    end else if (!wb_dat_i[0]) begin
                        state_d = S_FAULT;
                        code_n  = 2'd1;
                    end else begin
                        state_d = S_L2;
                    end
                end
            end
            S_L2: begin
                if (term) begin
                    if (kill) begin
                        state_d = S_IDLE;
                    end else if (wb_err_i) begin
                        state_d = S_FAULT;
                        code_n  = 2'd3;
                    end else if (!wb_dat_i[0]) begin
                        state_d = S_FAULT;
                        code_n  = 2'd2;
                    end else begin
                        state_d = S_UPDATE;
                    end
                end
            end
            S_UPDATE: state_d = S_IDLE;
            S_FAULT:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        vaddr_d = accept ? miss_vaddr : vaddr_q;
        base_d  = accept ? ptbr[31:12] : base_q;
        pte1_d  = (state_q == S_L1 && state_d == S_L2) ? wb_dat_i[31:12] : pte1_q;
        abort_d = (state_q == S_IDLE) ? 1'b0 : kill;
        busy_d  = (state_d != S_IDLE);
        cyc_d   = (state_d == S_L1) || (state_d == S_L2);
        upd_d   = (state_d == S_UPDATE);
        flt_d   = (state_d == S_FAULT);
        fv_d    = accept ? miss_vaddr : fault_vaddr;
        case (state_d)
            S_L1:    adr_d = {base_d, vaddr_d[31:22], 2'b00};
            S_L2:    adr_d = {pte1_d, vaddr_d[21:12], 2'b00};
            default: adr_d = wb_adr_o;
        endcase
        uv_d = upd_d ? {vaddr_q[31:12], 12'h000} : tlb_update_vaddr;
        up_d = upd_d ? {wb_dat_i[31:12], 12'h000} : tlb_update_paddr;
    end

endmodule

// File: tb/tb_lm32_tlb_refill.sv
// Randomized walks against a trace-level model: each walk is expanded into the per-cycle
// outputs it must produce, and one compare process checks the DUT against that trace.
module tb_lm32_tlb_refill;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] ptbr = '0;
    logic        miss_req = 1'b0;
    logic [31:0] miss_vaddr = '0;
    logic        miss_ack;
    logic        abort = 1'b0;
    logic        busy;
    logic [31:0] wb_adr_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_i = '0;
    logic        wb_ack_i = 1'b0, wb_err_i = 1'b0;
    logic        tlb_update;
    logic [31:0] tlb_update_vaddr, tlb_update_paddr;
    logic        refill_fault;
    logic [1:0]  fault_code;
    logic [31:0] fault_vaddr;

    lm32_tlb_refill #(.page_size(4096)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .ptbr(ptbr), .miss_req(miss_req),
        .miss_vaddr(miss_vaddr), .miss_ack(miss_ack), .abort(abort), .busy(busy),
        .wb_adr_o(wb_adr_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_sel_o(wb_sel_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
        .tlb_update(tlb_update), .tlb_update_vaddr(tlb_update_vaddr),
        .tlb_update_paddr(tlb_update_paddr), .refill_fault(refill_fault),
        .fault_code(fault_code), .fault_vaddr(fault_vaddr)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          chk, busy, cyc, mack, upd, flt, zero;
        logic [31:0] adr, uv, up, fv;
        logic [1:0]  code;
    } exp_t;

    localparam int HN = 8192;
    exp_t        exp_q[$];
    int          cyc_n = 0;
    int          checks = 0;
    int          errors = 0;
    bit          h_busy[HN], h_cyc[HN], h_upd[HN], h_flt[HN];
    logic [1:0]  h_code[HN];
    logic [31:0] h_adr[HN], h_uv[HN], h_up[HN], h_fv[HN];

    always @(posedge clk_i) cyc_n <= cyc_n + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc_n, act, want);
        end
    endtask

    function automatic exp_t base_e(input bit b, input bit c, input bit m);
        exp_t e;
        e.chk = 1; e.busy = b; e.cyc = c; e.mack = m; e.upd = 0; e.flt = 0; e.zero = 0;
        e.adr = '0; e.uv = '0; e.up = '0; e.fv = '0; e.code = 2'd0;
        return e;
    endfunction

    // Single compare process: one expected record per cycle.
    always @(negedge clk_i) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (e.chk) begin
                chk("busy", busy, e.busy);
                chk("cyc", wb_cyc_o, e.cyc);
                chk("stb", wb_stb_o, e.cyc);
                chk("miss_ack", miss_ack, e.mack);
                chk("tlb_update", tlb_update, e.upd);
                chk("refill_fault", refill_fault, e.flt);
                chk("fault_code", fault_code, e.code);
                chk("we", wb_we_o, 0);
                chk("sel", wb_sel_o, 4'hF);
                if (e.cyc) chk("adr", wb_adr_o, e.adr);
                if (e.upd) begin
                    chk("upd_vaddr", tlb_update_vaddr, e.uv);
                    chk("upd_paddr", tlb_update_paddr, e.up);
                end
                if (e.flt) chk("fault_vaddr", fault_vaddr, e.fv);
                if (e.zero) begin
                    chk("rst_adr", wb_adr_o, 0);
                    chk("rst_uv", tlb_update_vaddr, 0);
                    chk("rst_up", tlb_update_paddr, 0);
                    chk("rst_fv", fault_vaddr, 0);
                end
            end
        end
        if (cyc_n < HN) begin
            h_busy[cyc_n] = busy;      h_cyc[cyc_n] = wb_cyc_o;
            h_upd[cyc_n]  = tlb_update; h_flt[cyc_n] = refill_fault;
            h_code[cyc_n] = fault_code; h_adr[cyc_n] = wb_adr_o;
            h_uv[cyc_n]   = tlb_update_vaddr; h_up[cyc_n] = tlb_update_paddr;
            h_fv[cyc_n]   = fault_vaddr;
        end
    end

    task automatic drive(input bit req, input logic [31:0] va, input logic [31:0] pb,
                         input bit ab, input bit ack, input bit err, input logic [31:0] dat,
                         input bit rst, input exp_t e);
        @(posedge clk_i);
        #1;
        miss_req = req; miss_vaddr = va; ptbr = pb; abort = ab;
        wb_ack_i = ack; wb_err_i = err; wb_dat_i = dat; rst_i = rst;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(0, $urandom, $urandom, 1'($urandom_range(0, 1)), 0, 0, $urandom, 0, base_e(0, 0, 0));
    endtask

    task automatic fault(input logic [31:0] va, input logic [1:0] c, input bit hold);
        exp_t e;
        e = base_e(1, 0, 0);
        e.flt = 1; e.code = c; e.fv = va;
        drive(hold, $urandom, $urandom, 0, 0, 0, $urandom, 0, e);
    endtask

    // t1/t2: 0 = ack, 1 = err, 2 = ack and err together. ab_at counts bus cycles from L1 start.
    task automatic walk(input logic [31:0] pb, input logic [31:0] va, input logic [31:0] p1,
                        input logic [31:0] p2, input int w1, input int t1, input int w2,
                        input int t2, input int ab_at, input bit hold, input int rst_at,
                        output int t_acc);
        exp_t        e;
        int          off;
        bit          killed, ab, last;
        logic [31:0] a1, a2;
        drive(1, va, pb, 1'($urandom_range(0, 1)), 0, 0, $urandom, 0, base_e(0, 0, 1));
        t_acc  = cyc_n;
        a1     = {pb[31:12], va[31:22], 2'b00};
        a2     = {p1[31:12], va[21:12], 2'b00};
        off    = 0;
        killed = 0;
        for (int k = 0; k <= w1; k++) begin
            ab = (off == ab_at); killed |= ab; last = (k == w1);
            e = base_e(1, 1, 0); e.adr = a1;
            drive(hold, $urandom, $urandom, ab, last && t1 != 1, last && t1 != 0,
                  last ? p1 : $urandom, 0, e);
            off++;
        end
        if (killed) return;
        if (t1 != 0 || !p1[0]) begin
            fault(va, (t1 != 0) ? 2'd3 : 2'd1, hold);
            return;
        end
        for (int k = 0; k <= w2; k++) begin
            e = base_e(1, 1, 0); e.adr = a2;
            if (k == rst_at) begin
                drive(hold, $urandom, $urandom, 0, 0, 0, $urandom, 1, e);
                e = base_e(0, 0, 0); e.zero = 1;
                drive(0, $urandom, $urandom, 0, 0, 0, $urandom, 0, e);
                return;
            end
            ab = (off == ab_at); killed |= ab; last = (k == w2);
            drive(hold, $urandom, $urandom, ab, last && t2 != 1, last && t2 != 0,
                  last ? p2 : $urandom, 0, e);
            off++;
        end
        if (killed) return;
        if (t2 != 0 || !p2[0]) begin
            fault(va, (t2 != 0) ? 2'd3 : 2'd2, hold);
        end else begin
            e = base_e(1, 0, 0);
            e.upd = 1; e.uv = {va[31:12], 12'h000}; e.up = {p2[31:12], 12'h000};
            drive(hold, $urandom, $urandom, 0, 0, 0, $urandom, 0, e);
        end
    endtask

    function automatic int pick_term();
        int r;
        r = $urandom_range(0, 99);
        return (r < 85) ? 0 : (r < 95) ? 1 : 2;
    endfunction

    initial begin
        exp_t e;
        int   t, t2, dummy;
        logic [31:0] p1, p2;
        e = base_e(0, 0, 0);
        e.chk = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 1, e);
        drive(0, 0, 0, 0, 0, 0, 0, 1, e);
        e = base_e(0, 0, 0); e.zero = 1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, e);

        walk(32'h0010_0000, 32'h4000_1234, 32'h0020_0001, 32'h0ABC_D001, 0, 0, 0, 0, -1, 0, -1, t);
        idle(2);
        chk("lit_l1_adr", h_adr[t+1], 32'h0010_0400);
        chk("lit_l2_adr", h_adr[t+2], 32'h0020_0004);
        chk("lit_upd_at_t3", h_upd[t+3], 1);
        chk("lit_upd_vaddr", h_uv[t+3], 32'h4000_1000);
        chk("lit_upd_paddr", h_up[t+3], 32'h0ABC_D000);
        chk("lit_idle_t4", h_busy[t+4], 0);

        walk(32'h0010_0000, 32'h4000_1234, 32'h0020_0000, 32'h0, 0, 0, 0, 0, -1, 0, -1, t);
        idle(2);
        chk("lit_l1f_pulse", h_flt[t+2], 1);
        chk("lit_l1f_code", h_code[t+2], 2'd1);
        chk("lit_l1f_vaddr", h_fv[t+2], 32'h4000_1234);
        chk("lit_l1f_no_l2", h_cyc[t+2], 0);

        walk(32'h0010_0000, 32'h4000_1234, 32'h0020_0001, 32'h0ABC_D001, 0, 0, 3, 1, -1, 0, -1, t);
        idle(1);
        chk("lit_l2err_early", h_flt[t+5], 0);
        chk("lit_l2err_pulse", h_flt[t+6], 1);
        chk("lit_l2err_code", h_code[t+6], 2'd3);

        walk(32'h0010_0000, 32'h4000_1234, 32'h0020_0001, 32'h0ABC_D001, 3, 0, 0, 0, 1, 0, -1, t);
        walk(32'h0030_0000, 32'h8000_5678, 32'h0040_0001, 32'h0123_4001, 0, 0, 0, 0, -1, 0, -1, t2);
        idle(2);
        chk("lit_abort_cyc_held", h_cyc[t+4], 1);
        chk("lit_abort_idle", h_busy[t+5], 0);
        chk("lit_abort_reaccept", t2, t + 5);
        for (int i = 1; i <= 5; i++) chk("lit_abort_silent", h_upd[t+i] | h_flt[t+i], 0);

        walk(32'h0050_0000, 32'h1234_5000, 32'h0060_0001, 32'h0777_7001, 1, 0, 2, 0, -1, 1, -1, dummy);
        walk(32'h0050_0000, 32'hCAFE_0ABC, 32'h0060_0001, 32'h0777_7001, 0, 2, 0, 0, -1, 0, -1, dummy);
        idle(1);

        for (int n = 0; n < 200; n++) begin
            p1 = $urandom; p2 = $urandom;
            p1[0] = ($urandom_range(0, 99) < 85);
            p2[0] = ($urandom_range(0, 99) < 85);
            walk($urandom, $urandom, p1, p2, $urandom_range(0, 3), pick_term(),
                 $urandom_range(0, 3), pick_term(),
                 ($urandom_range(0, 9) == 0) ? $urandom_range(0, 8) : -1,
                 1'($urandom_range(0, 2) == 0), -1, dummy);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
        end

        walk(32'h0010_0000, 32'h4000_1234, 32'h0020_0001, 32'h0ABC_D001, 0, 0, 3, 0, -1, 0, 1, t);
        idle(2);
        chk("lit_rst_cyc", h_cyc[t+4], 0);
        chk("lit_rst_busy", h_busy[t+4], 0);
        chk("lit_rst_no_upd", h_upd[t+4] | h_upd[t+5], 0);

        @(negedge clk_i);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish, checks %0d", checks);
        $fatal(1);
    end

endmodule
